// File: rtl/cordic_iterative_hs.sv
// rtl/cordic_iterative_hs.sv - folded iterative CORDIC engine with valid/ready handshakes
// One micro-rotation per clock; rotation and vectoring modes with full-circle pre-correction.
module cordic_iterative_hs #(
   parameter int WIDTH    = 16,
   parameter int NUM_ITER = 14
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic             mode_i,
   input  logic [WIDTH-1:0] x_in_i,
   input  logic [WIDTH-1:0] y_in_i,
   input  logic [WIDTH-1:0] z_in_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH+1:0] x_out_o,
   output logic [WIDTH+1:0] y_out_o,
   output logic [WIDTH-1:0] z_out_o
);

   localparam int XW  = WIDTH + 2;
   localparam int CW  = $clog2(NUM_ITER);
   localparam int TAB = 1 << CW;
   localparam logic [CW-1:0] LAST = CW'(NUM_ITER - 1);
   localparam logic signed [WIDTH-1:0] QUARTER = {2'b01, {(WIDTH-2){1'b0}}};

   // atan(2^-i) scaled so that 2^(WIDTH-1) is pi; only ever evaluated at elaboration.
   function automatic logic [WIDTH-1:0] atan_const(input int i);
      real x;
      real pw;
      real sum;
      real v;
      if (i >= NUM_ITER) return '0;
      if (i == 0) return {3'b001, {(WIDTH-3){1'b0}}};
      x = 1.0;
      for (int k = 0; k < i; k++) x = x / 2.0;
      sum = 0.0;
      pw  = x;
      for (int n = 0; n < 40; n++) begin
         if (n % 2 == 0) sum = sum + pw / real'(2 * n + 1);
         else            sum = sum - pw / real'(2 * n + 1);
         pw = pw * x * x;
      end
      v = sum / 3.14159265358979323846;
      for (int k = 0; k < WIDTH - 1; k++) v = v * 2.0;
      return WIDTH'($rtoi(v + 0.5));
   endfunction

   logic [WIDTH-1:0] atan_tab [TAB];

   for (genvar g = 0; g < TAB; g++) begin : g_atan
      localparam logic [WIDTH-1:0] ATAN_G = atan_const(g);
      assign atan_tab[g] = ATAN_G;
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                  state_q;
   logic                    mode_q;
   logic                    in_ready_q;
   logic                    out_valid_q;
   logic [CW-1:0]           iter_q;
   logic signed [XW-1:0]    x_q, y_q, x_out_q, y_out_q;
   logic signed [WIDTH-1:0] z_q, z_out_q;

   logic signed [XW-1:0]    x_ext, y_ext, x0_d, y0_d, x_d, y_d, x_sh, y_sh;
   logic signed [WIDTH-1:0] z0_d, z_d, atan_cur;
   logic                    d_pos;

   always_comb begin
      x_ext = {{2{x_in_i[WIDTH-1]}}, x_in_i};
      y_ext = {{2{y_in_i[WIDTH-1]}}, y_in_i};
      x0_d  = x_ext;
      y0_d  = y_ext;
      z0_d  = z_in_i;
      if (mode_i) begin
         case (z_in_i[WIDTH-1 -: 2])
            2'b01: begin
               x0_d = -y_ext;
               y0_d = x_ext;
               z0_d = z_in_i - QUARTER;
            end
            2'b10: begin
               x0_d = y_ext;
               y0_d = -x_ext;
               z0_d = z_in_i + QUARTER;
            end
            default: begin
            end
         endcase
      end else if (x_in_i[WIDTH-1]) begin
         // Left half-plane: fold by +-90 degrees and seed the phase accordingly.
         if (!y_in_i[WIDTH-1]) begin
            x0_d = y_ext;
            y0_d = -x_ext;
            z0_d = QUARTER;
         end else begin
            x0_d = -y_ext;
            y0_d = x_ext;
            z0_d = -QUARTER;
         end
      end
   end

   always_comb begin
      x_sh     = x_q >>> iter_q;
      y_sh     = y_q >>> iter_q;
      atan_cur = atan_tab[iter_q];
      d_pos    = mode_q ? ~z_q[WIDTH-1] : y_q[XW-1];
      if (d_pos) begin
         x_d = x_q - y_sh;
         y_d = y_q + x_sh;
         z_d = z_q - atan_cur;
      end else begin
         x_d = x_q + y_sh;
         y_d = y_q - x_sh;
         z_d = z_q + atan_cur;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         mode_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         iter_q      <= '0;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         x_out_q     <= '0;
         y_out_q     <= '0;
         z_out_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid_i && in_ready_q) begin
                  mode_q     <= mode_i;
                  x_q        <= x0_d;
                  y_q        <= y0_d;
                  z_q        <= z0_d;
                  iter_q     <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= RUN;
               end else begin
                  in_ready_q <= 1'b1;
               end
            end
            RUN: begin
               x_q    <= x_d;
               y_q    <= y_d;
               z_q    <= z_d;
               iter_q <= iter_q + CW'(1);
               if (iter_q == LAST) begin
                  x_out_q     <= x_d;
                  y_out_q     <= y_d;
                  z_out_q     <= z_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign x_out_o     = x_out_q;
   assign y_out_o     = y_out_q;
   assign z_out_o     = z_out_q;

endmodule

// File: tb/tb_cordic_iterative_hs.sv
// tb/tb_cordic_iterative_hs.sv - directed self-checking bench for cordic_iterative_hs
// Hand-derived vectors plus an integer reference of the micro-rotation sequence.
module tb_cordic_iterative_hs;

   localparam int W = 16;
   localparam int N = 14;
   localparam int ATAN_T [14] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1};

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, mode, out_valid, out_ready;
   logic [W-1:0] x_in, y_in, z_in, z_out;
   logic [W+1:0] x_out, y_out;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   cordic_iterative_hs #(.WIDTH(W), .NUM_ITER(N)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .mode_i      (mode),
      .x_in_i      (x_in),
      .y_in_i      (y_in),
      .z_in_i      (z_in),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .x_out_o     (x_out),
      .y_out_o     (y_out),
      .z_out_o     (z_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_near(input string tag, input int obs, input int exp, input int tol, input bit wrap);
      int diff;
      logic signed [W-1:0] d16;
      diff = obs - exp;
      if (wrap) begin
         d16  = diff[W-1:0];
         diff = d16;
      end
      vectors++;
      assert ((diff <= tol && diff >= -tol) === 1'b1) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
      end
   endtask

   task automatic model(input bit m, input logic [W-1:0] xi, input logic [W-1:0] yi,
                        input logic [W-1:0] zi, output int xo, output int yo, output int zo);
      logic signed [W+1:0] x, y, xt;
      logic signed [W-1:0] z;
      x = {{2{xi[W-1]}}, xi};
      y = {{2{yi[W-1]}}, yi};
      z = zi;
      xt = x;
      if (m) begin
         if (zi[W-1:W-2] == 2'b01) begin
            x = -y; y = xt; z = z - 16'sd16384;
         end else if (zi[W-1:W-2] == 2'b10) begin
            x = y; y = -xt; z = z + 16'sd16384;
         end
      end else if (xi[W-1]) begin
         if (!yi[W-1]) begin
            x = y; y = -xt; z = 16'sd16384;
         end else begin
            x = -y; y = xt; z = -16'sd16384;
         end
      end
      for (int i = 0; i < N; i++) begin
         xt = x;
         if ((m && !z[W-1]) || (!m && y[W-1])) begin
            x = x - (y >>> i); y = y + (xt >>> i); z = z - 16'(ATAN_T[i]);
         end else begin
            x = x + (y >>> i); y = y - (xt >>> i); z = z + 16'(ATAN_T[i]);
         end
      end
      xo = x;
      yo = y;
      zo = z;
   endtask

   task automatic start_op(input bit m, input int xi, input int yi, input int zi);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check_eq("in_ready_before_accept", in_ready, 1);
      mode     = m;
      x_in     = W'(xi);
      y_in     = W'(yi);
      z_in     = W'(zi);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // Runs one operand to DONE and checks latency and the reference result; leaves the engine in DONE.
   task automatic do_op(input string tag, input bit m, input int xi, input int yi, input int zi,
                        output int xo, output int yo, output int zo);
      int lat, ex, ey, ez;
      start_op(m, xi, yi, zi);
      check_eq({tag, "_busy"}, in_ready, 0);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
      check_eq({tag, "_latency"}, lat, N);
      xo = $signed(x_out);
      yo = $signed(y_out);
      zo = $signed(z_out);
      model(m, W'(xi), W'(yi), W'(zi), ex, ey, ez);
      check_eq({tag, "_x_ref"}, xo, ex);
      check_eq({tag, "_y_ref"}, yo, ey);
      check_eq({tag, "_z_ref"}, zo, ez);
   endtask

   initial begin
      int xo, yo, zo, hx, hy, hz, ex, ey, ez, lat, n, acc, prev;
      int zs [5] = '{0, 16384, -16384, -32768, 8192};
      int xe [5] = '{32768, 0, 0, -32768, 23170};
      int ye [5] = '{0, 32768, -32768, 0, 23170};

      rst = 1'b1; in_valid = 1'b0; mode = 1'b0; out_ready = 1'b1;
      x_in = '0; y_in = '0; z_in = '0;
      tick(3);
      check_eq("reset_in_ready", in_ready, 0);
      check_eq("reset_out_valid", out_valid, 0);
      check_eq("reset_x_out", x_out, 0);
      check_eq("reset_y_out", y_out, 0);
      check_eq("reset_z_out", z_out, 0);
      rst = 1'b0;
      tick();
      check_eq("release_in_ready", in_ready, 1);

      for (int k = 0; k < 5; k++) begin
         do_op($sformatf("rot%0d", k), 1'b1, 19898, 0, zs[k], xo, yo, zo);
         check_near($sformatf("rot%0d_x", k), xo, xe[k], 6, 1'b0);
         check_near($sformatf("rot%0d_y", k), yo, ye[k], 6, 1'b0);
         check_near($sformatf("rot%0d_z", k), zo, 0, 2, 1'b1);
         tick();
         check_eq($sformatf("rot%0d_release_valid", k), out_valid, 0);
         check_eq($sformatf("rot%0d_release_ready", k), in_ready, 1);
      end

      do_op("vec_q1", 1'b0, 10000, 10000, 0, xo, yo, zo);
      check_near("vec_q1_x", xo, 23289, 6, 1'b0);
      check_near("vec_q1_y", yo, 0, 4, 1'b0);
      check_near("vec_q1_z", zo, 8192, 2, 1'b1);
      tick();
      do_op("vec_q3", 1'b0, -10000, -1, 0, xo, yo, zo);
      check_near("vec_q3_x", xo, 16468, 6, 1'b0);
      check_near("vec_q3_z", zo, -32768, 2, 1'b1);
      tick();

      // Backpressure: result must hold while extra operands are offered.
      out_ready = 1'b0;
      do_op("bp", 1'b1, 19898, 0, 4096, hx, hy, hz);
      for (int c = 0; c < 20; c++) begin
         in_valid = c[0];
         x_in = W'($urandom);
         z_in = W'($urandom);
         tick();
         check_eq("bp_out_valid", out_valid, 1);
         check_eq("bp_in_ready", in_ready, 0);
         check_eq("bp_x_hold", $signed(x_out), hx);
         check_eq("bp_y_hold", $signed(y_out), hy);
         check_eq("bp_z_hold", $signed(z_out), hz);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check_eq("bp_release_valid", out_valid, 0);
      check_eq("bp_release_ready", in_ready, 1);
      tick(20);
      check_eq("bp_nothing_queued", out_valid, 0);

      // Asynchronous reset during RUN discards the partial result.
      start_op(1'b1, 19898, 0, 8192);
      tick(7);
      check_eq("run_out_valid", out_valid, 0);
      check_eq("run_x_holds_last", $signed(x_out), hx);
      rst = 1'b1;
      #1;
      check_eq("midrst_out_valid", out_valid, 0);
      check_eq("midrst_x_out", x_out, 0);
      check_eq("midrst_y_out", y_out, 0);
      check_eq("midrst_z_out", z_out, 0);
      check_eq("midrst_in_ready", in_ready, 0);
      tick();
      rst = 1'b0;
      tick();
      do_op("after_rst", 1'b1, 19898, 0, -8192, xo, yo, zo);
      check_near("after_rst_x", xo, 23170, 6, 1'b0);
      check_near("after_rst_y", yo, -23170, 6, 1'b0);
      tick();

      // Back-to-back sweep with in_valid and out_ready held high.
      in_valid = 1'b1; mode = 1'b1; x_in = W'(19898); y_in = '0;
      prev = 0;
      for (int k = 0; k < 360; k++) begin
         n = 0;
         while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
         end
         z_in = W'(k * 182);
         tick();
         acc = cyc;
         if (k > 0) check_eq("b2b_period", acc - prev, N + 2);
         prev = acc;
         lat = 0;
         while (out_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
         end
         model(1'b1, W'(19898), '0, W'(k * 182), ex, ey, ez);
         check_eq($sformatf("b2b%0d_x", k), $signed(x_out), ex);
         check_eq($sformatf("b2b%0d_y", k), $signed(y_out), ey);
         check_eq($sformatf("b2b%0d_z", k), $signed(z_out), ez);
         tick();
      end
      in_valid = 1'b0;
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
